// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, buffer entry layout,
// and the opcode constants the control unit also uses.
package riscv_pkg;
  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/gnt/rvalid handling, in-order buffer, redirect
// flush with drop-counting of responses still in flight.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic [31:0]     Instruccion,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc, resp_pc;
  logic [CNT_W-1:0] outstanding, drop, outst_nxt, drop_nxt, fifo_count;
  logic            fifo_empty, issue, push, pop, room;
  fetch_entry_t    head;

  // Buffer space is reserved at issue, so a response can always be pushed.
  assign room      = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W+1)'(FIFO_DEPTH);
  assign imem_addr = pc;
  assign issue     = imem_req && imem_gnt;
  assign push      = imem_rvalid && (drop == '0) && !redirect;
  assign pop       = !fifo_empty && !stall && !redirect;
  assign outst_nxt = outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);

  always_comb begin
    drop_nxt  = drop;
    state_nxt = state;
    imem_req  = 1'b0;
    if (redirect)                        drop_nxt = outst_nxt;
    else if (imem_rvalid && drop != '0)  drop_nxt = drop - 1'b1;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = !redirect && room;
        if (redirect && drop_nxt != '0) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drop_nxt == '0) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outst_nxt;
      drop        <= drop_nxt;
      if (redirect) begin
        pc      <= redirect_pc & ~PC_W'(3);
        resp_pc <= redirect_pc & ~PC_W'(3);
      end else begin
        if (issue) pc      <= pc + PC_W'(4);
        if (push)  resp_pc <= resp_pc + PC_W'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({resp_pc, imem_rdata}),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign Instruccion = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc : resp_pc;

  a_outst_bound: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= CNT_W'(FIFO_DEPTH));
  a_drop_bound:  assert property (@(posedge clk) disable iff (!rst_n) drop <= CNT_W'(FIFO_DEPTH));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench: an epoch-tagged model of the fetch stream and a memory
// responder, compared against the DUT every falling edge.
module tb_instr_fetch_unit;
  import riscv_pkg::*;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, stall = 1'b0, instr_valid;
  logic [31:0] redirect_pc = '0, Instruccion, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .Instruccion(Instruccion), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  typedef struct { logic [31:0] addr; int ep; } tx_t;
  tx_t         mq[$];     // issued, not yet answered (memory order)
  logic [31:0] fq[$];     // delivered-to-buffer pcs, head first
  logic [31:0] seen[$];   // pcs consumed downstream
  logic [31:0] fetch_pc = RPC;
  int          ep = 0, nchk = 0, nfail = 0, gnt_pct = 100, rv_pct = 100;
  bit          boot = 1'b1, ident = 1'b1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ident ? a : ((a ^ 32'h5A5A_F00F) + 32'h0000_0101);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int occ, stale;
    bit exp_req, mvalid, acc;
    tx_t e;
    if (!rst_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", Instruccion, NOP_INSTR);
      chk("rst_pc", instr_pc, RPC);
      mq.delete(); fq.delete();
      fetch_pc = RPC; boot = 1'b1;
    end else begin
      stale = 0;
      foreach (mq[i]) if (mq[i].ep != ep) stale++;
      occ     = fq.size() + mq.size();
      exp_req = !boot && !redirect && stale == 0 && occ < DEPTH;
      mvalid  = fq.size() > 0;
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, fetch_pc);
      chk("instr_valid", instr_valid, mvalid);
      if (mvalid) begin
        chk("instr_pc", instr_pc, fq[0]);
        chk("Instruccion", Instruccion, word_at(fq[0]));
      end else chk("nop", Instruccion, NOP_INSTR);
      boot = 1'b0;
      acc = 1'b0;
      if (imem_rvalid && mq.size() > 0) begin
        e = mq.pop_front();
        acc = (e.ep == ep) && !redirect;
      end
      if (exp_req && imem_gnt) begin
        mq.push_back('{fetch_pc, ep});
        fetch_pc = fetch_pc + 32'd4;
      end
      if (redirect) begin
        fq.delete(); ep++;
        fetch_pc = redirect_pc & ~32'd3;
      end else begin
        if (mvalid && !stall) seen.push_back(fq.pop_front());
        if (acc) fq.push_back(e.addr);
      end
    end
  end

  // One cycle: wait for the edge, clear pulses, drive the memory side.
  task automatic step();
    @(posedge clk); #1;
    redirect = 1'b0; stall = 1'b0;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (rst_n && mq.size() > 0 && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1; imem_rdata = word_at(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: streaming with rdata == addr
    repeat (20) step();
    if (seen.size() >= 4) begin
      chk("t1_pc0", seen[0], 32'h0); chk("t1_pc1", seen[1], 32'h4);
      chk("t1_pc2", seen[2], 32'h8); chk("t1_pc3", seen[3], 32'hC);
    end else chk("t1_count", seen.size(), 4);
    step(); do_reset(2); ident = 1'b0;

    // 2: stall while streaming
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      step(); stall = 1'b1; #1;
      if (i == 3) chk("t2_req_held", imem_req, 0);
      if (i == 4) chk("t2_head_valid", instr_valid, 1);
    end
    repeat (4) step();

    // 3: redirect with two responses in flight
    rv_pct = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = (mq.size() == 2); end
    chk("t3_setup", mq.size(), 2);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step(); #1; chk("t3_drain_req", imem_req, 0);
    rv_pct = 100; got = 0;
    for (int i = 0; i < 30; i++) begin
      step(); #1;
      if (imem_req && !got) begin chk("t3_addr", imem_addr, 32'h100); got = 1; end
      if (instr_valid) begin chk("t3_first_pc", instr_pc, 32'h100); break; end
      if (i == 29) chk("t3_timeout", 0, 1);
    end

    // 4: unaligned redirect coincident with rvalid and stall
    repeat (3) step();
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = imem_rvalid; end
    chk("t4_rvalid_seen", got, 1);
    redirect = 1'b1; redirect_pc = 32'h0000_0203; stall = 1'b1;
    step(); #1; chk("t4_empty", instr_valid, 0);
    for (int i = 0; i < 20 && !imem_req; i++) begin step(); #1; end
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    repeat (4) step();

    // 5: grant withheld at the top of the address space, then wrap
    gnt_pct = 0;
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 20; i++) begin step(); #1; if (imem_req) break; end
    for (int i = 0; i < 10; i++) begin
      chk("t5_req", imem_req, 1); chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
      step(); #1;
    end
    gnt_pct = 100;
    step(); step(); #1;
    chk("t5_wrap_req", imem_req, 1); chk("t5_wrap_addr", imem_addr, 32'h0);

    // random traffic
    gnt_pct = 60; rv_pct = 50;
    for (int i = 0; i < 400; i++) begin
      step();
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 5) begin redirect = 1'b1; redirect_pc = $urandom; end
    end

    // 6: reset mid-stream
    gnt_pct = 100; rv_pct = 100;
    repeat (5) step();
    step(); rst_n = 1'b0; imem_rvalid = 1'b0; #1;
    chk("t6_req", imem_req, 0); chk("t6_valid", instr_valid, 0);
    chk("t6_instr", Instruccion, NOP_INSTR); chk("t6_addr", imem_addr, RPC);
    step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 5 && !imem_req; i++) begin step(); #1; end
    chk("t6_restart_req", imem_req, 1); chk("t6_restart_addr", imem_addr, RPC);
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
